// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: opcode encoding and FSM state type.
package instr_fetch_unit_pkg;

  localparam int OPCODE_WIDTH = 4;

  localparam logic [OPCODE_WIDTH-1:0] OP_NOP  = 4'h0;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 4'h1;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 4'h2;
  localparam logic [OPCODE_WIDTH-1:0] OP_MUL  = 4'h3;
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FINISH
  } fetch_state_t;

  function automatic logic is_halt(input logic [OPCODE_WIDTH-1:0] op);
    return op == OP_HALT;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_ins_bram.sv
// Instruction memory: simple dual-port RAM, one host write port and one registered read port.
module ins_bram #(
  parameter int AW = 8,
  parameter int DW = 35
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [0:(2**AW)-1];
  logic [DW-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: runs the program in the instruction BRAM one word per two-cycle slot,
// stops on HALT or at the end of memory, holds for the pipeline drain, then pulses done.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int INS_ADDR_WIDTH = 8,
  parameter int INS_WIDTH      = OPCODE_WIDTH + 3*ADDR_WIDTH + 1,
  parameter int DRAIN_SLOTS    = 3
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      prog_we,
  input  logic [INS_ADDR_WIDTH-1:0] prog_addr,
  input  logic [INS_WIDTH-1:0]      prog_data,
  output logic                      prog_err,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [INS_WIDTH-1:0]      instruction,
  output logic                      ins_valid,
  output logic [INS_ADDR_WIDTH-1:0] pc
);

  localparam int DCW = (DRAIN_SLOTS > 1) ? $clog2(DRAIN_SLOTS) : 1;
  localparam logic [INS_ADDR_WIDTH-1:0] LAST_ADDR = '1;

  fetch_state_t              r_state;
  logic                      r_phase;
  logic [INS_ADDR_WIDTH-1:0] r_addr;
  logic [INS_ADDR_WIDTH-1:0] r_pc;
  logic [DCW-1:0]            r_drain_cnt;
  logic [INS_WIDTH-1:0]      r_instr;
  logic                      r_valid;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_prog_err;
  logic                      r_rd_pending;
  logic                      r_last;

  logic                      w_wr_en;
  logic                      w_rd_en;
  logic [INS_WIDTH-1:0]      w_rd_data;
  logic                      w_halt;

  // Writes only land while idle and out of reset; busy also covers the done cycle.
  assign w_wr_en = prog_we && !r_busy && rstn;
  assign w_rd_en = (r_state == RUN) && !r_phase && !r_last;
  assign w_halt  = is_halt(w_rd_data[INS_WIDTH-1 -: OPCODE_WIDTH]);

  ins_bram #(
    .AW (INS_ADDR_WIDTH),
    .DW (INS_WIDTH)
  ) u_ins_bram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (prog_addr),
    .i_wr_data (prog_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_addr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_phase      <= 1'b0;
      r_addr       <= '0;
      r_pc         <= '0;
      r_drain_cnt  <= '0;
      r_instr      <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_prog_err   <= 1'b0;
      r_rd_pending <= 1'b0;
      r_last       <= 1'b0;
    end else begin
      r_phase      <= ~r_phase;
      r_done       <= 1'b0;
      r_prog_err   <= prog_we && r_busy;
      r_rd_pending <= w_rd_en;
      case (r_state)
        IDLE: begin
          if (start && !r_busy) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_addr  <= '0;
            r_pc    <= '0;
            r_last  <= 1'b0;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        RUN: begin
          // r_last marks that the final address has been issued: the next slot is an implicit HALT.
          if (r_phase) begin
            if (r_last || (r_rd_pending && w_halt)) begin
              r_instr     <= '0;
              r_valid     <= 1'b0;
              r_drain_cnt <= DCW'(DRAIN_SLOTS - 1);
              r_state     <= DRAIN;
            end else if (r_rd_pending) begin
              r_instr <= w_rd_data;
              r_valid <= (w_rd_data != '0);
              r_pc    <= r_addr;
              if (r_addr == LAST_ADDR) begin
                r_last <= 1'b1;
              end else begin
                r_addr <= r_addr + 1'b1;
              end
            end
          end
        end
        DRAIN: begin
          if (r_phase) begin
            if (r_drain_cnt == '0) begin
              r_state <= FINISH;
            end else begin
              r_drain_cnt <= r_drain_cnt - 1'b1;
            end
          end
        end
        FINISH: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign prog_err    = r_prog_err;
  assign busy        = r_busy;
  assign done        = r_done;
  assign instruction = r_instr;
  assign ins_valid   = r_valid;
  assign pc          = r_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus pushes expected issues/done, a monitor pops and compares.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  localparam int IW = OPCODE_WIDTH + 3*10 + 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          prog_we = 1'b0;
  logic [7:0]    prog_addr = '0;
  logic [IW-1:0] prog_data = '0;
  logic          start = 1'b0;
  logic          prog_err, busy, done, ins_valid;
  logic [IW-1:0] instruction;
  logic [7:0]    pc;

  instr_fetch_unit dut (
    .clk         (clk),
    .rstn        (rstn),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_err    (prog_err),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .instruction (instruction),
    .ins_valid   (ins_valid),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int cyc_start = 0;
  int err_cycles = 0;
  bit mon_en = 0;
  bit done_seen = 0;

  typedef enum {K_ISSUE, K_DONE} kind_t;
  typedef struct {
    kind_t         kind;
    logic [IW-1:0] instr;
    logic [7:0]    pc;
    int            min_cyc;
  } exp_t;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [IW-1:0] mk(input logic [3:0] op, input int d, input int a, input int b);
    logic [9:0] d10, a10, b10;
    d10 = 10'(d);
    a10 = 10'(a);
    b10 = 10'(b);
    return {op, d10, a10, b10, 1'b1};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic pop_issue();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL unexpected_issue: got instr %0h pc %0d expected nothing", instruction, pc);
    end else begin
      e = sb.pop_front();
      if (e.kind != K_ISSUE) begin
        n_cmp++; n_fail++;
        $display("FAIL issue_kind: got issue pc %0d expected done", pc);
      end else begin
        check("issue_instr", 64'(instruction), 64'(e.instr));
        check("issue_pc", 64'(pc), 64'(e.pc));
        $display("txn issue pc=%0d instr=%h", pc, instruction);
      end
    end
  endtask

  task automatic pop_done();
    exp_t e;
    int diff;
    done_seen = 1;
    diff = cyc - cyc_start;
    if (sb.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL unexpected_done: got done at +%0d cycles expected nothing", diff);
    end else begin
      e = sb.pop_front();
      if (e.kind != K_DONE) begin
        n_cmp++; n_fail++;
        $display("FAIL done_kind: got done expected issue pc %0d", e.pc);
      end else begin
        n_cmp++;
        if (diff < e.min_cyc || diff > e.min_cyc + 1) begin
          n_fail++;
          $display("FAIL done_latency: got %0d expected %0d..%0d", diff, e.min_cyc, e.min_cyc + 1);
        end
        check("busy_at_done", 64'(busy), 64'd1);
        $display("txn done after %0d cycles", diff);
      end
    end
  endtask

  // Monitor: one pop per newly presented word and per done pulse.
  logic          hold_valid = 1'b0;
  logic [IW-1:0] hold_instr = '0;
  logic [7:0]    hold_pc = '0;
  int            hold_len = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (ins_valid) begin
        if (hold_valid && instruction == hold_instr && pc == hold_pc) begin
          hold_len++;
        end else begin
          if (hold_valid) check("hold_cycles", 64'(hold_len), 64'd2);
          pop_issue();
          hold_valid = 1'b1;
          hold_instr = instruction;
          hold_pc    = pc;
          hold_len   = 1;
        end
      end else begin
        if (hold_valid) check("hold_cycles", 64'(hold_len), 64'd2);
        hold_valid = 1'b0;
        check("nop_when_invalid", 64'(instruction), 64'd0);
      end
      if (done) pop_done();
      if (prog_err) err_cycles++;
    end
  end

  task automatic cycle_in(input logic we, input logic [7:0] a, input logic [IW-1:0] d,
                          input logic st, input bit rec);
    @(posedge clk); #1;
    prog_we = we; prog_addr = a; prog_data = d; start = st;
    @(posedge clk); #1;
    if (rec) cyc_start = cyc;
    prog_we = 1'b0; start = 1'b0;
  endtask

  task automatic push_issue(input logic [IW-1:0] d, input logic [7:0] p);
    exp_t e;
    e.kind = K_ISSUE; e.instr = d; e.pc = p; e.min_cyc = 0;
    sb.push_back(e);
  endtask

  task automatic push_done(input int min_cyc);
    exp_t e;
    e.kind = K_DONE; e.instr = '0; e.pc = '0; e.min_cyc = min_cyc;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int budget, input string name);
    int k;
    k = 0;
    while (!done_seen && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (!done_seen) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout: got no done in %0d cycles expected done", name, budget);
    end
    @(negedge clk);
    check({name, "_busy_after"}, 64'(busy), 64'd0);
    check({name, "_queue_empty"}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  logic [IW-1:0] w_a, w_b, w_c, w_d, w_halt;

  initial begin
    w_a    = mk(OP_SUB, 5, 6, 7);
    w_b    = mk(OP_MUL, 8, 9, 10);
    w_c    = mk(OP_ADD, 11, 12, 13);
    w_d    = mk(OP_SUB, 20, 21, 22);
    w_halt = mk(OP_HALT, 0, 0, 0);

    // 1: reset under random stimulus, then idle
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      prog_we   = 1'($urandom_range(0, 1));
      start     = 1'($urandom_range(0, 1));
      prog_addr = 8'($urandom);
      prog_data = IW'({$urandom, $urandom});
    end
    @(posedge clk); #1;
    rstn = 1'b1; prog_we = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_instruction", 64'(instruction), 64'd0);
    check("rst_ins_valid", 64'(ins_valid), 64'd0);
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_prog_err", 64'(prog_err), 64'd0);
    mon_en = 1;

    // 2: three ADD words then HALT
    for (int i = 0; i < 3; i++) cycle_in(1'b1, 8'(i), mk(OP_ADD, i + 1, i + 2, i + 3), 1'b0, 1'b0);
    cycle_in(1'b1, 8'd3, w_halt, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) push_issue(mk(OP_ADD, i + 1, i + 2, i + 3), 8'(i));
    push_done(2 * (3 + 1 + 3) + 1);
    done_seen = 0;
    cycle_in(1'b0, 8'd0, '0, 1'b1, 1'b1);
    wait_done(40, "t2");

    // 3: HALT at address 0
    cycle_in(1'b1, 8'd0, w_halt, 1'b0, 1'b0);
    push_done(2 * (0 + 1 + 3) + 1);
    done_seen = 0;
    cycle_in(1'b0, 8'd0, '0, 1'b1, 1'b1);
    wait_done(30, "t3");

    // 4: full memory without HALT, implicit halt at the last address
    for (int i = 0; i < 256; i++) cycle_in(1'b1, 8'(i), mk(OP_ADD, i, i + 1, i + 2), 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) push_issue(mk(OP_ADD, i, i + 1, i + 2), 8'(i));
    push_done(2 * (256 + 1 + 3) + 1);
    done_seen = 0;
    cycle_in(1'b0, 8'd0, '0, 1'b1, 1'b1);
    wait_done(600, "t4");
    check("t4_pc_held_last", 64'(pc), 64'd255);

    // 5: prog_we and start mid-run are rejected
    cycle_in(1'b1, 8'd0, w_a, 1'b0, 1'b0);
    cycle_in(1'b1, 8'd1, w_b, 1'b0, 1'b0);
    cycle_in(1'b1, 8'd2, w_c, 1'b0, 1'b0);
    cycle_in(1'b1, 8'd3, w_halt, 1'b0, 1'b0);
    push_issue(w_a, 8'd0); push_issue(w_b, 8'd1); push_issue(w_c, 8'd2);
    push_done(15);
    done_seen = 0;
    err_cycles = 0;
    cycle_in(1'b0, 8'd0, '0, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    cycle_in(1'b1, 8'd1, mk(OP_MUL, 99, 99, 99), 1'b1, 1'b0);
    wait_done(40, "t5_run1");
    check("t5_prog_err_cycles", 64'(err_cycles), 64'd1);
    push_issue(w_a, 8'd0); push_issue(w_b, 8'd1); push_issue(w_c, 8'd2);
    push_done(15);
    done_seen = 0;
    cycle_in(1'b0, 8'd0, '0, 1'b1, 1'b1);
    wait_done(40, "t5_run2");

    // 6: reset pulse mid-run, then a fresh run with a same-cycle write and start
    push_issue(w_a, 8'd0);
    done_seen = 0;
    cycle_in(1'b0, 8'd0, '0, 1'b1, 1'b1);
    begin
      int k;
      k = 0;
      while (sb.size() != 0 && k < 10) begin
        @(posedge clk);
        k++;
      end
      if (sb.size() != 0) begin
        n_cmp++; n_fail++;
        $display("FAIL t6_first_issue_timeout: got %0d pending expected 0", sb.size());
      end
    end
    #1 rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    check("t6_instruction", 64'(instruction), 64'd0);
    check("t6_ins_valid", 64'(ins_valid), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_pc", 64'(pc), 64'd0);
    repeat (30) @(posedge clk);
    check("t6_no_done", 64'(done_seen), 64'd0);
    push_issue(w_d, 8'd0); push_issue(w_b, 8'd1); push_issue(w_c, 8'd2);
    push_done(15);
    done_seen = 0;
    cycle_in(1'b1, 8'd0, w_d, 1'b1, 1'b1);
    wait_done(40, "t6_rerun");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
